// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic                  we;
        logic                  lock;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant with lock override.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       lock_active,
    input  logic       lock_owner,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        // A held lock shuts the other port out even while the owner is idle.
        if (lock_active) begin
            grant[lock_owner] = valid[lock_owner];
        end else if (valid == 2'b11) begin
            grant[~last_grant] = 1'b1;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one combinational-read DMem between the CPU port (0) and the loader port (1):
// accept, one access cycle, then a one-cycle response pulse on the originating port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic                  req_lock_0,
    input  logic [ADDR_WIDTH-1:0] req_addr_0,
    input  logic [DATA_WIDTH-1:0] req_wdata_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic                  req_lock_1,
    input  logic [ADDR_WIDTH-1:0] req_addr_1,
    input  logic [DATA_WIDTH-1:0] req_wdata_1,
    output logic                  rsp_valid_0,
    output logic [DATA_WIDTH-1:0] rsp_rdata_0,
    output logic                  rsp_valid_1,
    output logic [DATA_WIDTH-1:0] rsp_rdata_1,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_e            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  lock_active_q, lock_active_d;
    logic                  lock_owner_q, lock_owner_d;
    logic                  hold_we_q, hold_we_d;
    logic                  hold_port_q, hold_port_d;
    logic [ADDR_WIDTH-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_WIDTH-1:0] hold_wdata_q, hold_wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_port_q, rsp_port_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0] grant;
    logic       in_idle;
    logic       in_access;
    logic       sel_port;

    rr_arb2 u_rr_arb2 (
        .valid       ({req_valid_1, req_valid_0}),
        .last_grant  (last_grant_q),
        .lock_active (lock_active_q),
        .lock_owner  (lock_owner_q),
        .grant       (grant)
    );

    assign in_idle   = (state_q == ARB_IDLE);
    assign in_access = (state_q == ARB_ACCESS);
    assign sel_port  = grant[1] ? PORT_LDR : PORT_CPU;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        hold_we_d     = hold_we_q;
        hold_port_d   = hold_port_q;
        hold_addr_d   = hold_addr_q;
        hold_wdata_d  = hold_wdata_q;
        rsp_valid_d   = 1'b0;
        rsp_port_d    = rsp_port_q;
        rsp_rdata_d   = rsp_rdata_q;
        if (in_idle) begin
            if (grant != 2'b00) begin
                state_d       = ARB_ACCESS;
                last_grant_d  = sel_port;
                hold_port_d   = sel_port;
                hold_we_d     = sel_port ? req_we_1    : req_we_0;
                hold_addr_d   = sel_port ? req_addr_1  : req_addr_0;
                hold_wdata_d  = sel_port ? req_wdata_1 : req_wdata_0;
                lock_active_d = sel_port ? req_lock_1  : req_lock_0;
                lock_owner_d  = sel_port;
            end
        end else begin
            state_d     = ARB_IDLE;
            rsp_valid_d = 1'b1;
            rsp_port_d  = hold_port_q;
            rsp_rdata_d = hold_we_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            last_grant_q  <= PORT_LDR;
            lock_active_q <= 1'b0;
            lock_owner_q  <= PORT_CPU;
            hold_we_q     <= 1'b0;
            hold_port_q   <= PORT_CPU;
            hold_addr_q   <= '0;
            hold_wdata_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_port_q    <= PORT_CPU;
            rsp_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            hold_we_q     <= hold_we_d;
            hold_port_q   <= hold_port_d;
            hold_addr_q   <= hold_addr_d;
            hold_wdata_q  <= hold_wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_port_q    <= rsp_port_d;
            rsp_rdata_q   <= rsp_rdata_d;
        end
    end

    // Readies are gated by rst_n so every output is quiet while reset is held.
    assign req_ready_0 = grant[0] & in_idle & rst_n;
    assign req_ready_1 = grant[1] & in_idle & rst_n;

    assign mem_we    = in_access & hold_we_q;
    assign mem_re    = in_access & ~hold_we_q;
    assign mem_addr  = in_access ? hold_addr_q  : '0;
    assign mem_wdata = in_access ? hold_wdata_q : '0;

    assign rsp_valid_0 = rsp_valid_q & (rsp_port_q == PORT_CPU);
    assign rsp_valid_1 = rsp_valid_q & (rsp_port_q == PORT_LDR);
    assign rsp_rdata_0 = rsp_valid_0 ? rsp_rdata_q : '0;
    assign rsp_rdata_1 = rsp_valid_1 ? rsp_rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural combinational-read DMem.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_0 = 1'b0, req_we_0 = 1'b0, req_lock_0 = 1'b0;
    logic        req_valid_1 = 1'b0, req_we_1 = 1'b0, req_lock_1 = 1'b0;
    logic [31:0] req_addr_0 = '0, req_wdata_0 = '0, req_addr_1 = '0, req_wdata_1 = '0;
    logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1;
    logic [31:0] rsp_rdata_0, rsp_rdata_1;
    logic        mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] dmem [0:255] = '{4: 32'hDEADBEEF, default: 32'h0};

    typedef struct {
        bit          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    bit   acc_port[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_we_0(req_we_0),
        .req_lock_0(req_lock_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_we_1(req_we_1),
        .req_lock_1(req_lock_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_rdata_0(rsp_rdata_0),
        .rsp_valid_1(rsp_valid_1), .rsp_rdata_1(rsp_rdata_1),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign mem_rdata = dmem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (rst_n && mem_we) dmem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: logs accepts and checks every response against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid_0 && req_ready_0) begin
                acc_port.push_back(1'b0);
                acc_cyc.push_back(cyc);
            end
            if (req_valid_1 && req_ready_1) begin
                acc_port.push_back(1'b1);
                acc_cyc.push_back(cyc);
            end
            if (rsp_valid_0 || rsp_valid_1) begin
                chk("rsp_one_hot", {31'd0, rsp_valid_0 & rsp_valid_1}, 32'd0);
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", {31'd0, rsp_valid_1}, 32'hFFFFFFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_port", {31'd0, rsp_valid_1}, {31'd0, e.port});
                    chk("rsp_rdata", rsp_valid_1 ? rsp_rdata_1 : rsp_rdata_0, e.data);
                    chk("rsp_cycle", cyc, e.cyc);
                    chk("rsp_other_rdata", rsp_valid_1 ? rsp_rdata_0 : rsp_rdata_1, 32'd0);
                end
            end
        end
    end

    task automatic set_port(input bit p, input bit v, input bit we, input bit lock,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p) begin
            req_valid_1 = v; req_we_1 = we; req_lock_1 = lock; req_addr_1 = addr; req_wdata_1 = wdata;
        end else begin
            req_valid_0 = v; req_we_0 = we; req_lock_0 = lock; req_addr_0 = addr; req_wdata_0 = wdata;
        end
    endtask

    task automatic send(input bit p, input bit we, input bit lock, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        set_port(p, 1'b1, we, lock, addr, wdata);
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (p ? req_ready_1 : req_ready_0) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout: port %0d got no ready, required within 40 cycles", p);
        end else begin
            sb.push_back('{p, (we ? 32'd0 : exp_rd), cyc + 2});
        end
        @(posedge clk); #1;
        set_port(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_acc(input string name, input logic [7:0] exp_ports, input int n);
        chk({name, "_count"}, acc_port.size(), n);
        for (int i = 0; i < n && i < acc_port.size(); i++) begin
            chk({name, "_port"}, {31'd0, acc_port[i]}, {31'd0, exp_ports[i]});
            if (i > 0) chk({name, "_spacing"}, acc_cyc[i] - acc_cyc[i-1], 32'd2);
        end
        acc_port.delete();
        acc_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_mem_re", {31'd0, mem_re}, 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        bit got;
        // Reset state: outputs quiet even with both requesters valid.
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        #12;
        chk("reset_ready_0", {31'd0, req_ready_0}, 32'd0);
        chk("reset_ready_1", {31'd0, req_ready_1}, 32'd0);
        chk("reset_mem_we", {31'd0, mem_we}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single read from port 0.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("t1_ready_0", {31'd0, req_ready_0}, 32'd1);
        chk("t1_ready_1", {31'd0, req_ready_1}, 32'd0);
        sb.push_back('{1'b0, 32'hDEADBEEF, cyc + 2});
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_mem_re", {31'd0, mem_re}, 32'd1);
        chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
        chk("t1_mem_addr", mem_addr, 32'h10);
        @(negedge clk);
        chk("t1_rsp_valid_0", {31'd0, rsp_valid_0}, 32'd1);
        chk("t1_rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
        acc_port.delete();
        acc_cyc.delete();

        // Contention straight after reset: port 0 first.
        do_reset();
        fork
            send(1'b0, 1'b1, 1'b0, 32'h20, 32'h1, 32'h0);
            send(1'b1, 1'b1, 1'b0, 32'h24, 32'h2, 32'h0);
        join
        repeat (3) @(negedge clk);
        check_acc("contention", 8'b0000_0010, 2);
        chk("contention_mem20", dmem[8], 32'h1);
        chk("contention_mem24", dmem[9], 32'h2);

        // Round-robin with both ports continuously requesting.
        fork
            repeat (4) send(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1);
            repeat (4) send(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 32'h2);
        join
        repeat (3) @(negedge clk);
        check_acc("round_robin", 8'b1010_1010, 8);

        // Write response carries zero data; readback sees the write.
        send(1'b1, 1'b1, 1'b0, 32'h40, 32'hA5A5A5A5, 32'h0);
        send(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5);
        repeat (3) @(negedge clk);
        check_acc("write_rsp", 8'b0000_0001, 2);

        // Lock: three port-1 transfers before port 0 gets in.
        fork
            begin
                send(1'b1, 1'b1, 1'b1, 32'h44, 32'h11, 32'h0);
                send(1'b1, 1'b1, 1'b1, 32'h48, 32'h22, 32'h0);
                send(1'b1, 1'b1, 1'b0, 32'h4C, 32'h33, 32'h0);
            end
            send(1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h11);
        join
        repeat (3) @(negedge clk);
        check_acc("lock", 8'b0000_0111, 4);

        // Reset during the access cycle of a port-0 write.
        @(posedge clk); #1;
        set_port(1'b0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h55);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (req_ready_0) got = 1'b1;
        end
        chk("midrst_accept", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("midrst_we_before", {31'd0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we_after", {31'd0, mem_we}, 32'd0);
        chk("midrst_addr_after", mem_addr, 32'h0);
        repeat (2) @(negedge clk);
        chk("midrst_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd0);
        rst_n = 1'b1;
        chk("midrst_mem30", dmem[12], 32'h0);
        acc_port.delete();
        acc_cyc.delete();
        fork
            send(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
            send(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h1);
        join
        repeat (3) @(negedge clk);
        check_acc("post_reset", 8'b0000_0010, 2);

        chk("final_sb_empty", sb.size(), 32'd0);
        chk("final_mem40", dmem[16], 32'hA5A5A5A5);
        chk("final_mem44", dmem[17], 32'h11);
        chk("final_mem48", dmem[18], 32'h22);
        chk("final_mem4c", dmem[19], 32'h33);
        chk("final_mem30", dmem[12], 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, required before 50000 time units");
        $fatal(1, "watchdog");
    end

endmodule
